// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Types shared by the memory arbiter and its neighbours.
//   ramstate_t  : status returned by the RAM model each cycle
//   arb_state_t : arbiter FSM states
//   src_t       : identifies which requester was served last
// -----------------------------------------------------------------------------
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RAM_FREE   = 2'd0,
      RAM_BUSY   = 2'd1,
      RAM_ACCESS = 2'd2,
      RAM_ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_IGRANT = 2'd1,
      ARB_DGRANT = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } src_t;

   localparam logic [7:0] ERRCNT_MAX = 8'hFF;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported RAM between an instruction fetch port and a data
// port. At most one RAM transaction is in flight; when both ports request at
// once the grant alternates so neither side can starve.
//
// Ports
//   CLK, RST                 : clock, synchronous active-high reset
//   iREN, iaddr              : instruction read request / word address
//   iwait, iload             : instruction stall / read data
//   dREN, dWEN, daddr, dstore: data read / write request, address, write data
//   dwait, dload             : data stall / read data
//   ramREN, ramWEN           : RAM read / write strobes
//   ramaddr, ramstore        : RAM address / write data
//   ramload, ramstate        : RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   errcnt                   : saturating count of ERROR responses seen
// -----------------------------------------------------------------------------
module mem_arbiter
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   // instruction port
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   // data port
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   // RAM side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   // status
   output logic [7:0]  errcnt
);

   arb_state_t  state_q,    state_d;
   src_t        last_src_q, last_src_d;
   logic [7:0]  errcnt_q,   errcnt_d;

   ramstate_t   ram_st;
   logic        dreq;

   assign ram_st = ramstate_t'(ramstate);
   assign dreq   = dREN | dWEN;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ARB_IDLE;
         last_src_q <= SRC_DATA;   // instruction side wins the first tie
         errcnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_src_q <= last_src_d;
         errcnt_q   <= errcnt_d;
      end
   end

   // Next-state logic.
   // NOTE: every variable gets a default at the top of the block; without it
   // some path through the case would leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      last_src_d = last_src_q;
      errcnt_d   = errcnt_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (dreq && (!iREN || last_src_q == SRC_INSTR)) begin
               state_d = ARB_DGRANT;
            end else if (iREN) begin
               state_d = ARB_IGRANT;
            end
         end
         ARB_IGRANT: begin
            // A withdrawn request aborts even if the RAM completes this cycle.
            if (!iREN) begin
               state_d = ARB_IDLE;
            end else if (ram_st == RAM_ACCESS) begin
               state_d    = ARB_IDLE;
               last_src_d = SRC_INSTR;
            end
         end
         ARB_DGRANT: begin
            if (!dreq) begin
               state_d = ARB_IDLE;
            end else if (ram_st == RAM_ACCESS) begin
               state_d    = ARB_IDLE;
               last_src_d = SRC_DATA;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      // ERROR keeps the grant in place (retry) and is only counted.
      if (state_q != ARB_IDLE && ram_st == RAM_ERROR && errcnt_q != ERRCNT_MAX) begin
         errcnt_d = errcnt_q + 8'd1;
      end
   end

   // Output logic: decoded from the current state. RST forces the idle view
   // so a transaction caught by reset never reports completion.
   always_comb begin
      iwait    = 1'b1;
      iload    = '0;
      dwait    = 1'b1;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;

      if (!RST) begin
         unique case (state_q)
            ARB_IGRANT: begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (iREN && ram_st == RAM_ACCESS) begin
                  iwait = 1'b0;
                  iload = ramload;
               end
            end
            ARB_DGRANT: begin
               // Read and write together is treated as a write.
               ramREN   = dREN & ~dWEN;
               ramWEN   = dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (dreq && ram_st == RAM_ACCESS) begin
                  dwait = 1'b0;
                  dload = ramload;
               end
            end
            default: ;
         endcase
      end
   end

   assign errcnt = errcnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a hand-written vector table, a long
// ERROR-retry sequence, and randomized traffic compared against a
// transaction-level model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   typedef struct packed {
      logic        iwait;
      logic [31:0] iload;
      logic        dwait;
      logic [31:0] dload;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic [7:0]  errcnt;
   } out_t;

   typedef struct {
      bit          rst;
      bit          iren;
      bit          dren;
      bit          dwen;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [31:0] dstore;
      logic [31:0] ramload;
      logic [1:0]  ramstate;
      out_t        exp;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic [7:0]  errcnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: who holds the RAM (0 none, 1 instruction, 2 data),
   // whether the last completed transfer was an instruction fetch, and errors.
   int m_owner;
   bit m_last_instr;
   int m_err;

   vec_t tbl[$];

   mem_arbiter dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .errcnt(errcnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input out_t act, input out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic out_t o(bit iw, logic [31:0] il, bit dw, logic [31:0] dl,
                              bit ren, bit wen, logic [31:0] addr, logic [31:0] st);
      out_t r;
      r = '{iwait: iw, iload: il, dwait: dw, dload: dl, ren: ren, wen: wen,
            addr: addr, store: st, errcnt: 8'd0};
      return r;
   endfunction

   task automatic add(input bit rst, input bit ir, input bit dr, input bit dw,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] ds, input logic [31:0] rl,
                      input logic [1:0] rs, input out_t e);
      vec_t v;
      v.rst = rst; v.iren = ir; v.dren = dr; v.dwen = dw;
      v.iaddr = ia; v.daddr = da; v.dstore = ds; v.ramload = rl;
      v.ramstate = rs; v.exp = e;
      tbl.push_back(v);
   endtask

   // Expected outputs this cycle, from the model's view of who owns the RAM.
   function automatic out_t model_out();
      out_t r;
      bool_access: begin end
      r = '{iwait: 1'b1, iload: '0, dwait: 1'b1, dload: '0, ren: 1'b0,
            wen: 1'b0, addr: '0, store: '0, errcnt: 8'(m_err)};
      if (!RST) begin
         if (m_owner == 1) begin
            r.ren  = 1'b1;
            r.addr = iaddr;
            if (iREN && ramstate == 2'd2) begin
               r.iwait = 1'b0;
               r.iload = ramload;
            end
         end else if (m_owner == 2) begin
            r.wen   = dWEN;
            r.ren   = dREN && !dWEN;
            r.addr  = daddr;
            r.store = dstore;
            if ((dREN || dWEN) && ramstate == 2'd2) begin
               r.dwait = 1'b0;
               r.dload = ramload;
            end
         end
      end
      return r;
   endfunction

   // Advance the model across one rising edge using the applied inputs.
   task automatic model_edge();
      bit want_d;
      if (RST) begin
         m_owner = 0; m_last_instr = 1'b0; m_err = 0;
         return;
      end
      if (m_owner != 0 && ramstate == 2'd3 && m_err < 255) m_err++;
      want_d = dREN || dWEN;
      case (m_owner)
         0: begin
            if (want_d && (!iREN || m_last_instr)) m_owner = 2;
            else if (iREN)                          m_owner = 1;
         end
         1: begin
            if (!iREN) m_owner = 0;
            else if (ramstate == 2'd2) begin m_owner = 0; m_last_instr = 1'b1; end
         end
         default: begin
            if (!want_d) m_owner = 0;
            else if (ramstate == 2'd2) begin m_owner = 0; m_last_instr = 1'b0; end
         end
      endcase
   endtask

   // One cycle: settle, compare with model (and optional table value), clock.
   task automatic step(input string name, input bit has_exp, input out_t e,
                       output out_t act);
      #1;
      act = '{iwait: iwait, iload: iload, dwait: dwait, dload: dload,
              ren: ramREN, wen: ramWEN, addr: ramaddr, store: ramstore,
              errcnt: errcnt};
      check({name, "/model"}, act, model_out());
      if (has_exp) check(name, act, e);
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit rst, input bit ir, input bit dr, input bit dw,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] ds, input logic [31:0] rl,
                        input logic [1:0] rs);
      RST = rst; iREN = ir; dREN = dr; dWEN = dw;
      iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
   endtask

   initial begin
      out_t z, act, none;
      int lows;

      z    = o(1, 0, 1, 0, 0, 0, 0, 0);
      none = z;

      // Initial reset edge, not checked: flop contents are unknown before it.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge CLK);
      model_edge();
      #1;

      // ---------------- table-driven vectors ----------------
      add(1,0,0,0, 0,0,0, 0, 0, z);
      // single fetch: two BUSY then ACCESS
      add(0,1,0,0, 'h100,0,0, 'h2402000A, 0, z);
      add(0,1,0,0, 'h100,0,0, 'h2402000A, 1, o(1,0,1,0,1,0,'h100,0));
      add(0,1,0,0, 'h100,0,0, 'h2402000A, 1, o(1,0,1,0,1,0,'h100,0));
      add(0,1,0,0, 'h100,0,0, 'h2402000A, 2, o(0,'h2402000A,1,0,1,0,'h100,0));
      add(0,0,0,0, 0,0,0, 'h2402000A, 0, z);
      // tie after reset: instruction, data, instruction
      add(1,0,0,0, 0,0,0, 0, 0, z);
      add(0,1,1,0, 'h40,'h80,0, 'h11, 0, z);
      add(0,1,1,0, 'h40,'h80,0, 'h11, 2, o(0,'h11,1,0,1,0,'h40,0));
      add(0,1,1,0, 'h40,'h80,0, 'h11, 0, z);
      add(0,1,1,0, 'h40,'h80,0, 'h11, 2, o(1,0,0,'h11,1,0,'h80,0));
      add(0,1,1,0, 'h40,'h80,0, 'h11, 0, z);
      add(0,1,1,0, 'h40,'h80,0, 'h11, 2, o(0,'h11,1,0,1,0,'h40,0));
      // data write held until ACCESS
      add(0,0,0,1, 0,'h200,'hDEADBEEF, 'h55, 0, z);
      add(0,0,0,1, 0,'h200,'hDEADBEEF, 'h55, 1, o(1,0,1,0,0,1,'h200,'hDEADBEEF));
      add(0,0,0,1, 0,'h200,'hDEADBEEF, 'h55, 0, o(1,0,1,0,0,1,'h200,'hDEADBEEF));
      add(0,0,0,1, 0,'h200,'hDEADBEEF, 'h55, 2, o(1,0,0,'h55,0,1,'h200,'hDEADBEEF));
      add(0,0,0,0, 0,0,0, 'h55, 0, z);
      // read+write together is a write
      add(0,0,1,1, 0,'h300,'h12345678, 'h55, 0, z);
      add(0,0,1,1, 0,'h300,'h12345678, 'h55, 2, o(1,0,0,'h55,0,1,'h300,'h12345678));
      add(0,0,0,0, 0,0,0, 'h55, 0, z);
      // fetch withdrawn mid-grant, ACCESS arriving the same cycle
      add(0,1,0,0, 'h500,0,0, 'h77, 0, z);
      add(0,1,0,0, 'h500,0,0, 'h77, 1, o(1,0,1,0,1,0,'h500,0));
      add(0,0,0,0, 'h500,0,0, 'h77, 2, o(1,0,1,0,1,0,'h500,0));
      add(0,0,0,0, 'h500,0,0, 'h77, 0, z);
      // reset during a data grant
      add(0,0,1,0, 0,'h600,0, 'h88, 0, z);
      add(0,0,1,0, 0,'h600,0, 'h88, 1, o(1,0,1,0,1,0,'h600,0));
      add(1,0,1,0, 0,'h600,0, 'h88, 2, z);
      add(0,0,0,0, 0,0,0, 'h88, 0, z);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].iaddr,
               tbl[i].daddr, tbl[i].dstore, tbl[i].ramload, tbl[i].ramstate);
         step($sformatf("vec%0d", i), 1'b1, tbl[i].exp, act);
      end

      // ---------------- ERROR retry and counter saturation ----------------
      drive(0, 0, 1, 0, 0, 'h700, 0, 'hCAFE0001, 0);
      step("err_req", 1'b0, none, act);
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         ramstate = 2'd3;
         step("err_retry", 1'b0, none, act);
         if (!act.dwait) lows++;
         if (i == 100) check_int("errcnt_mid", int'(act.errcnt), 100);
      end
      ramstate = 2'd2;
      step("err_access", 1'b0, none, act);
      if (!act.dwait) lows++;
      check_int("errcnt_sat", int'(act.errcnt), 255);
      check_int("err_dload", int'(act.dload), int'(32'hCAFE0001));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("err_after", 1'b0, none, act);
      check_int("err_dwait_lows", lows, 1);
      check_int("errcnt_hold", int'(act.errcnt), 255);
      RST = 1'b1;
      step("err_rst", 1'b0, none, act);
      RST = 1'b0;
      step("err_cleared", 1'b0, none, act);
      check_int("errcnt_reset", int'(act.errcnt), 0);

      // ---------------- randomized traffic vs. model ----------------
      for (int i = 0; i < 3000; i++) begin
         RST      = ($urandom_range(0, 99) == 0);
         iREN     = ($urandom_range(0, 3) != 0);
         dREN     = ($urandom_range(0, 2) == 0);
         dWEN     = ($urandom_range(0, 3) == 0);
         iaddr    = $urandom;
         daddr    = $urandom;
         dstore   = $urandom;
         ramload  = $urandom;
         ramstate = 2'($urandom_range(0, 3));
         step("rand", 1'b0, none, act);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK in 1, system clock; RST in 1, synchronous active-high reset.
REQ-002 SHALL have ports: iREN in 1, instruction read request; iaddr in 32, instruction word address; iwait out 1, instruction stall; iload out 32, instruction read data.
REQ-003 SHALL have ports: dREN in 1, data read request; dWEN in 1, data write request; daddr in 32, data address; dstore in 32, write data; dwait out 1, data stall; dload out 32, data read data.
REQ-004 SHALL have ports: ramREN out 1; ramWEN out 1; ramaddr out 32; ramstore out 32; ramload in 32; ramstate in 2, RAM status (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-005 SHALL have output errcnt out 8, saturating count of ERROR responses.

Function
REQ-006 SHALL implement FSM states IDLE, IGRANT, DGRANT; one RAM transaction in flight at most.
REQ-007 IDLE: data request (dREN|dWEN) with iREN low, or last_src=INSTR -> DGRANT next cycle.
REQ-008 IDLE: iREN with no data request, or both pending and last_src=DATA -> IGRANT next cycle; alternation prevents starvation.
REQ-009 IDLE with no request SHALL stay IDLE; ram outputs all zero.
REQ-010 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr; DGRANT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; all combinational from state.
REQ-011 dREN and dWEN both high SHALL be treated as write only (ramREN=0).
REQ-012 iwait SHALL be 0 only in IGRANT cycle where ramstate==ACCESS; dwait likewise in DGRANT; otherwise both 1.
REQ-013 iload=ramload and dload=ramload passed through combinationally; valid only when corresponding wait is 0; otherwise 0.
REQ-014 On ACCESS in a grant state: FSM -> IDLE next cycle, last_src updated to granted source.
REQ-015 BUSY or FREE in a grant state: stay, hold ram outputs stable.
REQ-016 ERROR in a grant state: stay (retry), errcnt increments by 1, saturates at 255.
REQ-017 Granted source deasserting its request mid-grant: abort to IDLE next cycle, wait stays 1, last_src unchanged.
REQ-018 Minimum latency: request in IDLE at cycle 0, grant at cycle 1, wait low at cycle 1 if RAM returns ACCESS that cycle; back-to-back requests from same source need one IDLE cycle between them.

Reset
REQ-019 RST sampled on CLK rising edge: state=IDLE, last_src=DATA (instruction wins first tie), errcnt=0.
REQ-020 During/after reset: iwait=1, dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
REQ-021 Reset mid-grant SHALL abandon transaction without asserting any wait low.

Structure
REQ-022 ramstate_t encodings and arbiter state enum SHALL live in cpu_types_pkg; port bundles reuse existing caches interface types.
REQ-023 Single flat module; no sub-modules.

Verification
REQ-024 iREN=1 iaddr=0x100, RAM ACCESS after 2 BUSY -> iwait low exactly 1 cycle at cycle 3, iload=ramload=0x2402000A, FSM IDLE at cycle 4.
REQ-025 iREN and dREN asserted together after reset -> IGRANT first; then DGRANT; then IGRANT (alternation).
REQ-026 dWEN=1 daddr=0x200 dstore=0xDEADBEEF -> ramWEN=1 ramREN=0 ramaddr=0x200 ramstore=0xDEADBEEF until ACCESS; dwait low 1 cycle.
REQ-027 DGRANT with ramstate ERROR for 300 cycles, then ACCESS -> errcnt=255 saturated, dwait low once.
REQ-028 IGRANT, iREN drops before ACCESS -> IDLE next cycle, iwait never low; RST mid-DGRANT -> all outputs reset values next cycle.
